// File: rtl/bcd_to_bin.sv
// bcd_to_bin: converts two switch-entered BCD digits to binary on a button
// press and shows the result on LEDR and as two hex digits on HEX5/HEX4.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous reset, active-high
//   KEY1     - raw translate button, active-low, asynchronous to clk
//   switches - BCD input: [7:4] tens digit, [3:0] ones digit
//   LEDR     - binary result, zero-extended to 8 bits
//   HEX4     - right hex digit of result, {g,f,e,d,c,b,a}, active-high
//   HEX5     - left hex digit of result, same encoding
//   LEDG8    - set when the last translated input was not valid BCD
//   busy     - high while a conversion is in progress
module bcd_to_bin #(
    parameter logic [6:0] ZERO_SEG    = 7'b0111111,
    parameter logic [6:0] INVALID_SEG = 7'b1100011,
    parameter int         STEP        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       KEY1,
    input  logic [7:0] switches,
    output logic [7:0] LEDR,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       LEDG8,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ACCUM,
        DONE
    } state_t;

    state_t     state;
    state_t     next_state;

    logic       k1;
    logic       k2;
    logic       press;
    logic [7:0] sw_q;
    logic [6:0] acc;
    logic [3:0] cnt;
    logic       invalid;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // Two-flop synchroniser; press fires once on the cycle after the
    // synchronised level goes from released to pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            k1    <= 1'b1;
            k2    <= 1'b1;
            press <= 1'b0;
        end else begin
            k1    <= KEY1;
            k2    <= k1;
            press <= ~k1 & k2;
        end
    end

    assign invalid = (sw_q[7:4] > 4'd9) || (sw_q[3:0] > 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (press) next_state = CHECK;
            CHECK: next_state = invalid ? IDLE : ACCUM;
            ACCUM: if (cnt == 4'd0) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            LEDR  <= 8'd0;
            HEX4  <= ZERO_SEG;
            HEX5  <= ZERO_SEG;
            LEDG8 <= 1'b0;
            busy  <= 1'b0;
            sw_q  <= 8'd0;
            acc   <= 7'd0;
            cnt   <= 4'd0;
        end else begin
            // Registered from next_state so busy lines up with state.
            busy <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (press) sw_q <= switches;
                end
                CHECK: begin
                    if (invalid) begin
                        HEX4  <= INVALID_SEG;
                        HEX5  <= INVALID_SEG;
                        LEDG8 <= 1'b1;
                        LEDR  <= 8'd0;
                    end else begin
                        acc <= {3'b000, sw_q[3:0]};
                        cnt <= sw_q[7:4];
                    end
                end
                ACCUM: begin
                    if (cnt != 4'd0) begin
                        acc <= acc + 7'(STEP);
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    LEDR  <= {1'b0, acc};
                    HEX4  <= seg(acc[3:0]);
                    HEX5  <= seg({1'b0, acc[6:4]});
                    LEDG8 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed self-checking bench for bcd_to_bin.
// Drives KEY1/switches and checks LEDR, HEX4/5, LEDG8 and busy timing.
module tb_bcd_to_bin;

    logic       clk;
    logic       rst;
    logic       KEY1;
    logic [7:0] switches;
    logic [7:0] LEDR;
    logic [6:0] HEX4;
    logic [6:0] HEX5;
    logic       LEDG8;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_to_bin dut (
        .clk(clk),
        .rst(rst),
        .KEY1(KEY1),
        .switches(switches),
        .LEDR(LEDR),
        .HEX4(HEX4),
        .HEX5(HEX5),
        .LEDG8(LEDG8),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold KEY1 low for 'low' cycles then release; run 'total' cycles,
    // counting press pulses, busy-high cycles and busy rising edges.
    task automatic drive_key(input logic [7:0] sw, input int low,
                             input int total, output int presses,
                             output int bcyc, output int rises);
        logic pb;
        presses  = 0;
        bcyc     = 0;
        rises    = 0;
        pb       = busy;
        switches = sw;
        KEY1     = 1'b0;
        for (int i = 0; i < total; i++) begin
            if (i == low) KEY1 = 1'b1;
            tick();
            presses += int'(dut.press);
            bcyc    += int'(busy);
            if (busy && !pb) rises++;
            pb = busy;
        end
        KEY1 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        KEY1 = 1'b1;
        switches = 8'h00;
        repeat (3) tick();
        n_cmp++;
        if ({LEDR, HEX4, HEX5, LEDG8, busy, dut.press} !==
            {8'h00, 7'b0111111, 7'b0111111, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: got LEDR=%h HEX4=%b HEX5=%b G8=%b busy=%b, need 00/0111111/0111111/0/0",
                     LEDR, HEX4, HEX5, LEDG8, busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_max();
        int p, b, r;
        drive_key(8'h99, 5, 40, p, b, r);
        n_cmp++;
        if (p !== 1) begin
            n_bad++;
            $display("FAIL max_press: got %0d pulses, need 1", p);
        end
        n_cmp++;
        if (b !== 12) begin
            n_bad++;
            $display("FAIL max_busy: got %0d cycles, need 12", b);
        end
        n_cmp++;
        if ({LEDR, HEX5, HEX4, LEDG8} !==
            {8'h63, 7'b1111101, 7'b1001111, 1'b0}) begin
            n_bad++;
            $display("FAIL max_out: got LEDR=%h HEX5=%b HEX4=%b G8=%b, need 63/1111101/1001111/0",
                     LEDR, HEX5, HEX4, LEDG8);
        end
    endtask

    task automatic test_zero();
        int p, b, r;
        drive_key(8'h00, 3, 30, p, b, r);
        n_cmp++;
        if (b !== 3) begin
            n_bad++;
            $display("FAIL zero_busy: got %0d cycles, need 3", b);
        end
        n_cmp++;
        if ({LEDR, HEX5, HEX4, LEDG8} !==
            {8'h00, 7'b0111111, 7'b0111111, 1'b0}) begin
            n_bad++;
            $display("FAIL zero_out: got LEDR=%h HEX5=%b HEX4=%b G8=%b, need 00/0111111/0111111/0",
                     LEDR, HEX5, HEX4, LEDG8);
        end
    endtask

    task automatic test_invalid();
        int p, b, r;
        drive_key(8'h4A, 3, 30, p, b, r);
        n_cmp++;
        if (b !== 1) begin
            n_bad++;
            $display("FAIL inv_busy: got %0d cycles, need 1", b);
        end
        n_cmp++;
        if ({LEDR, HEX5, HEX4, LEDG8, busy} !==
            {8'h00, 7'b1100011, 7'b1100011, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL inv_out: got LEDR=%h HEX5=%b HEX4=%b G8=%b busy=%b, need 00/1100011/1100011/1/0",
                     LEDR, HEX5, HEX4, LEDG8, busy);
        end
        drive_key(8'h42, 3, 30, p, b, r);
        n_cmp++;
        if ({LEDR, HEX5, HEX4, LEDG8} !==
            {8'h2A, 7'b1011011, 7'b1110111, 1'b0}) begin
            n_bad++;
            $display("FAIL after_inv: got LEDR=%h HEX5=%b HEX4=%b G8=%b, need 2a/1011011/1110111/0",
                     LEDR, HEX5, HEX4, LEDG8);
        end
    endtask

    task automatic test_back_to_back();
        int rises;
        int presses;
        logic pb;
        rises = 0;
        presses = 0;
        pb = busy;
        switches = 8'h57;
        KEY1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) KEY1 = 1'b1;
            if (i == 5) begin
                switches = 8'h11;
                KEY1 = 1'b0;
            end
            if (i == 7) KEY1 = 1'b1;
            tick();
            presses += int'(dut.press);
            if (busy && !pb) rises++;
            pb = busy;
        end
        n_cmp++;
        if (presses !== 2 || rises !== 1) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d pulses %0d conversions, need 2 and 1",
                     presses, rises);
        end
        n_cmp++;
        if ({LEDR, HEX5, HEX4} !== {8'h39, 7'b1001111, 7'b1101111}) begin
            n_bad++;
            $display("FAIL b2b_out: got LEDR=%h HEX5=%b HEX4=%b, need 39/1001111/1101111",
                     LEDR, HEX5, HEX4);
        end
    endtask

    task automatic test_reset_mid();
        int p, b, r;
        drive_key(8'h90, 2, 6, p, b, r);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy: got busy=%b, need 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({LEDR, HEX4, HEX5, LEDG8, busy} !==
            {8'h00, 7'b0111111, 7'b0111111, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset: got LEDR=%h HEX4=%b HEX5=%b G8=%b busy=%b, need reset values",
                     LEDR, HEX4, HEX5, LEDG8, busy);
        end
        b = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            b += int'(busy);
        end
        n_cmp++;
        if (b !== 0 || {LEDR, HEX4, HEX5, LEDG8} !==
            {8'h00, 7'b0111111, 7'b0111111, 1'b0}) begin
            n_bad++;
            $display("FAIL post_reset: got busy cycles=%0d LEDR=%h HEX4=%b HEX5=%b, need 0/00/0111111/0111111",
                     b, LEDR, HEX4, HEX5);
        end
    endtask

    task automatic test_hold();
        int p, b, r;
        drive_key(8'h12, 100, 120, p, b, r);
        n_cmp++;
        if (p !== 1 || r !== 1) begin
            n_bad++;
            $display("FAIL hold_count: got %0d pulses %0d conversions, need 1 and 1", p, r);
        end
        n_cmp++;
        if (b !== 4) begin
            n_bad++;
            $display("FAIL hold_busy: got %0d cycles, need 4", b);
        end
        n_cmp++;
        if ({LEDR, HEX4, HEX5} !== {8'h0C, 7'b0111001, 7'b0111111}) begin
            n_bad++;
            $display("FAIL hold_out: got LEDR=%h HEX4=%b HEX5=%b, need 0c/0111001/0111111",
                     LEDR, HEX4, HEX5);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Inverse of the board's binary-to-decimal display path. Reads two BCD digits from switches: tens in switches[7:4], ones in switches[3:0].
- On a translate button press, converts the digits to binary with an iterative add-by-ten FSM.
- Shows the binary result on LEDR and as two hex digits on HEX5/HEX4. Flags non-BCD input on LEDG8.
- Top-level board block: KEY/switch inputs, LED/7-seg outputs.

Parameters:
- ZERO_SEG, 7'b0111111, segment pattern shown after reset ("0").
- INVALID_SEG, 7'b1100011, pattern shown on both digits for non-BCD input.
- STEP, 10, value added per tens iteration (radix).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- KEY1  input  1  raw translate button, active-low (pressed = 0), asynchronous to clk
- switches  input  8  BCD input: [7:4] tens, [3:0] ones
- LEDR  output  8  binary result, zero-extended
- HEX4  output  7  right hex digit of result, segments {g,f,e,d,c,b,a}, active-high
- HEX5  output  7  left hex digit of result, same encoding
- LEDG8  output  1  invalid-input flag
- busy  output  1  high while a conversion is in progress

Behaviour:
- Button synchroniser:
  - KEY1 passes through two flops, k1 then k2. Both reset to 1 (released).
  - Registered press pulse: press <= ~k1 & k2, i.e. one cycle per falling edge.
  - Holding KEY1 low produces exactly one pulse. Release produces none.
- Reset values: LEDR=0, HEX4=HEX5=ZERO_SEG, LEDG8=0, busy=0, state=IDLE, press=0. Reset overrides all other activity.
- FSM states: IDLE, CHECK, ACCUM, DONE.
- IDLE:
  - When press=1, capture switches into sw_q and go to CHECK.
  - Otherwise hold. Outputs hold their last values.
- CHECK:
  - If sw_q[7:4]>9 or sw_q[3:0]>9: set HEX4=HEX5=INVALID_SEG, LEDG8=1, LEDR=0, then go to IDLE.
  - Else: acc<=sw_q[3:0] zero-extended to 7 bits, cnt<=sw_q[7:4], then go to ACCUM.
- ACCUM:
  - If cnt==0, go to DONE.
  - Else acc<=acc+STEP and cnt<=cnt-1, staying in ACCUM.
  - Max acc = 99 = 7'h63, so no overflow is possible.
- DONE:
  - Set LEDR<={1'b0,acc}, HEX4<=seg(acc[3:0]), HEX5<=seg({1'b0,acc[6:4]}), LEDG8<=0.
  - Go to IDLE.
- busy = 1 in CHECK, ACCUM and DONE; 0 in IDLE (registered from the state).
- Latency, counted from cycle P where press=1 in IDLE:
  - Invalid input: outputs change at the end of cycle P+1.
  - Valid input: outputs change at the end of cycle P+2+T+1, where T = tens digit (T ACCUM iterations plus one exit cycle).
  - busy is high in cycles P+1 through the DONE cycle.
- Press pulses while busy=1 are dropped, not queued. switches changes after capture do not affect the running conversion.
- Reset mid-conversion: abort, apply reset values, and do not publish a partial result.
- seg() font, active-high {g..a}:
  - 0 0111111, 1 0000110, 2 1011011, 3 1001111
  - 4 1100110, 5 1101101, 6 1111101, 7 0000111
  - 8 1111111, 9 1101111, A 1110111, b 1111100
  - C 0111001, d 1011110, E 1111001, F 1110001
- LEDG8 stays at its last value until the next CHECK/DONE completes or reset.

Test Plan:
- Reset, then switches=8'h99 and a 5-cycle KEY1 low pulse:
  - one press pulse;
  - busy high for 12 cycles (CHECK + 10 ACCUM + DONE);
  - then LEDR=8'h63, HEX5=1111101, HEX4=1001111, LEDG8=0.
- switches=8'h00, press:
  - DONE reached in 3 cycles after P;
  - LEDR=0, HEX4=HEX5=0111111, LEDG8=0.
- switches=8'h4A, press:
  - at P+2, HEX4=HEX5=1100011, LEDG8=1, LEDR=0, busy=0;
  - then switches=8'h42 with a press gives LEDR=8'h2A, HEX5=1011011, HEX4=1110111, LEDG8=0.
- switches=8'h57, press; then while busy, press again with switches=8'h11:
  - second press ignored;
  - final LEDR=8'h39 (57), HEX5=1001111, HEX4=1101111.
- switches=8'h90, press; assert rst for one cycle during ACCUM:
  - all outputs return to reset values;
  - no later update without a new press.
- Hold KEY1 low 100 cycles with switches=8'h12:
  - exactly one conversion;
  - LEDR=8'h0C, HEX4=0111001, HEX5=0111111.
